// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port synchronous video RAM between display
// fetch (always first) and a host read/write port, and generates the display
// fetch address from the mode latched at the start of each frame.
module vram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              AnG,
    input  logic [2:0]        GMode,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic              FrameStart,
    input  logic              LineEnd,
    input  logic              FetchReq,
    input  logic              HostReq,
    input  logic              HostWe,
    input  logic [ADDR_W-1:0] HostAddr,
    input  logic [DATA_W-1:0] HostWData,
    output logic              HostAck,
    output logic [DATA_W-1:0] HostRData,
    output logic [ADDR_W-1:0] RamAddr,
    output logic              RamWe,
    output logic [DATA_W-1:0] RamWData,
    input  logic [DATA_W-1:0] RamRData,
    output logic [DATA_W-1:0] VidData,
    output logic              VidValid,
    output logic              FetchOverrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VID,
        S_VCAP,
        S_HOST,
        S_HCAP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_go_vid;
    logic                w_go_host;

    logic                r_pend;
    logic                r_overrun;
    logic                r_host_ack;
    logic                r_host_we;
    logic                r_vid_valid;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic [DATA_W-1:0]   r_host_rdata;
    logic [DATA_W-1:0]   r_vid_data;

    logic                r_ang;
    logic [2:0]          r_gmode;
    logic [ADDR_W-1:0]   r_line_start;
    logic [ADDR_W-1:0]   r_col;
    logic [3:0]          r_rep;
    logic [ADDR_W-1:0]   w_bpl;
    logic [3:0]          w_rep_last;
    logic [ADDR_W-1:0]   w_disp_addr;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Slot arbitration and next state: a pending or fresh fetch beats the host.
    always_comb begin
        w_go_vid  = 1'b0;
        w_go_host = 1'b0;
        w_next    = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_pend || FetchReq) begin
                    w_go_vid = 1'b1;
                    w_next   = S_VID;
                end else if (HostReq && !r_host_ack) begin
                    w_go_host = 1'b1;
                    w_next    = S_HOST;
                end
            end
            S_VID:   w_next = S_VCAP;
            S_VCAP:  w_next = S_IDLE;
            S_HOST:  w_next = S_HCAP;
            S_HCAP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bytes per line and (repeat count - 1) for the latched mode.
    always_comb begin
        w_bpl      = ADDR_W'(32);
        w_rep_last = 4'd11;
        if (r_ang) begin
            case (r_gmode)
                3'b000, 3'b001: begin w_bpl = ADDR_W'(16); w_rep_last = 4'd2; end
                3'b010:         begin w_bpl = ADDR_W'(32); w_rep_last = 4'd2; end
                3'b011:         begin w_bpl = ADDR_W'(16); w_rep_last = 4'd1; end
                3'b100:         begin w_bpl = ADDR_W'(32); w_rep_last = 4'd1; end
                3'b101:         begin w_bpl = ADDR_W'(16); w_rep_last = 4'd0; end
                default:        begin w_bpl = ADDR_W'(32); w_rep_last = 4'd0; end
            endcase
        end
    end

    assign w_disp_addr = r_line_start + r_col;

    // Pending-fetch flag and sticky overrun; a request seen while one is pending is lost.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pend    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (FetchReq && r_pend) r_overrun <= 1'b1;
            if (w_go_vid)           r_pend    <= 1'b0;
            else if (FetchReq)      r_pend    <= 1'b1;
        end
    end

    // Display address generator; col advances on the grant edge, after the
    // current address has been loaded into RamAddr, so a same-edge LineEnd
    // still lets this fetch use the pre-reset column.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ang        <= 1'b0;
            r_gmode      <= '0;
            r_line_start <= '0;
            r_col        <= '0;
            r_rep        <= '0;
        end else if (FrameStart) begin
            r_ang        <= AnG;
            r_gmode      <= GMode;
            r_line_start <= BaseAddr;
            r_col        <= '0;
            r_rep        <= '0;
        end else if (LineEnd) begin
            r_col <= '0;
            if (r_rep == w_rep_last) begin
                r_rep        <= '0;
                r_line_start <= r_line_start + w_bpl;
            end else begin
                r_rep <= r_rep + 4'd1;
            end
        end else if (w_go_vid) begin
            r_col <= r_col + ADDR_W'(1);
        end
    end

    // RAM port, captured read data and completion pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_host_we    <= 1'b0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
            r_vid_valid  <= 1'b0;
            r_vid_data   <= '0;
        end else begin
            r_ram_we    <= 1'b0;
            r_host_ack  <= (r_state == S_HCAP);
            r_vid_valid <= (r_state == S_VCAP);
            if (w_go_vid) begin
                r_ram_addr <= w_disp_addr;
            end else if (w_go_host) begin
                r_ram_addr  <= HostAddr;
                r_ram_we    <= HostWe;
                r_ram_wdata <= HostWData;
                r_host_we   <= HostWe;
            end
            if (r_state == S_VCAP)
                r_vid_data <= RamRData;
            if (r_state == S_HCAP && !r_host_we)
                r_host_rdata <= RamRData;
        end
    end

    assign HostAck      = r_host_ack;
    assign HostRData    = r_host_rdata;
    assign RamAddr      = r_ram_addr;
    assign RamWe        = r_ram_we;
    assign RamWData     = r_ram_wdata;
    assign VidData      = r_vid_data;
    assign VidValid     = r_vid_valid;
    assign FetchOverrun = r_overrun;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: RAM model plus address/data reference for vram_arbiter.
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          AnG = 1'b0;
    logic [2:0]    GMode = '0;
    logic [AW-1:0] BaseAddr = '0;
    logic          FrameStart = 1'b0;
    logic          LineEnd = 1'b0;
    logic          FetchReq = 1'b0;
    logic          HostReq = 1'b0;
    logic          HostWe = 1'b0;
    logic [AW-1:0] HostAddr = '0;
    logic [DW-1:0] HostWData = '0;
    logic          HostAck;
    logic [DW-1:0] HostRData;
    logic [AW-1:0] RamAddr;
    logic          RamWe;
    logic [DW-1:0] RamWData;
    logic [DW-1:0] RamRData;
    logic [DW-1:0] VidData;
    logic          VidValid;
    logic          FetchOverrun;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(Clk), .Reset(Reset), .AnG(AnG), .GMode(GMode), .BaseAddr(BaseAddr),
        .FrameStart(FrameStart), .LineEnd(LineEnd), .FetchReq(FetchReq),
        .HostReq(HostReq), .HostWe(HostWe), .HostAddr(HostAddr), .HostWData(HostWData),
        .HostAck(HostAck), .HostRData(HostRData), .RamAddr(RamAddr), .RamWe(RamWe),
        .RamWData(RamWData), .RamRData(RamRData), .VidData(VidData), .VidValid(VidValid),
        .FetchOverrun(FetchOverrun)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge Clk) cyc++;

    // RAM environment (what the DUT really did) and golden contents (what should be there).
    logic [DW-1:0] ram    [8192];
    logic [DW-1:0] golden [8192];
    always @(posedge Clk) begin
        if (RamWe) ram[RamAddr] <= RamWData;
        RamRData <= ram[RamAddr];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Frame model: address = base + (line / R) * B + col, modulo 2^AW.
    int gb [8] = '{16, 16, 32, 16, 32, 16, 32, 32};
    int gr [8] = '{3, 3, 3, 2, 2, 1, 1, 1};
    int fm_base, fm_B, fm_R, fm_line, fm_col;

    function automatic logic [AW-1:0] exp_addr();
        return AW'(fm_base + (fm_line / fm_R) * fm_B + fm_col);
    endfunction

    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
    } fetch_t;
    fetch_t vq [$];
    int min_lat = 3;
    int max_lat = 3;

    fetch_t mon_f;
    int     mon_lat;
    // Scoreboard: each VidValid retires the oldest outstanding fetch.
    always @(negedge Clk) begin
        if (!Reset && VidValid) begin
            check_eq("vid_expected", 32'(vq.size() > 0), 1);
            if (vq.size() > 0) begin
                mon_f   = vq.pop_front();
                mon_lat = cyc - mon_f.cyc;
                check_eq("vid_data", 32'(VidData), 32'(golden[mon_f.addr]));
                check_eq("vid_latency", 32'(mon_lat >= min_lat && mon_lat <= max_lat), 1);
            end
        end
    end

    task automatic frame_start(input logic ang, input logic [2:0] gm, input logic [AW-1:0] base);
        @(posedge Clk); #1;
        AnG = ang; GMode = gm; BaseAddr = base; FrameStart = 1'b1;
        fm_base = int'(base);
        fm_B    = ang ? gb[gm] : 32;
        fm_R    = ang ? gr[gm] : 12;
        fm_line = 0;
        fm_col  = 0;
        @(posedge Clk); #1;
        FrameStart = 1'b0;
        // mid-frame changes must have no effect
        AnG = 1'($urandom); GMode = 3'($urandom); BaseAddr = AW'($urandom);
    endtask

    task automatic fetch(input int gap, input bit chk_addr);
        fetch_t t;
        @(posedge Clk); #1;
        FetchReq = 1'b1;
        t.addr = exp_addr();
        t.cyc  = cyc;
        vq.push_back(t);
        fm_col++;
        @(posedge Clk); #1;
        FetchReq = 1'b0;
        if (chk_addr) begin
            @(negedge Clk);
            check_eq("ram_addr", 32'(RamAddr), 32'(t.addr));
            check_eq("ram_we_vid", 32'(RamWe), 0);
        end
        repeat (gap - 2) @(posedge Clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && vq.size() > 0; i++) @(posedge Clk);
        @(negedge Clk);
        check_eq("vid_drained", 32'(vq.size()), 0);
        vq.delete();
    endtask

    task automatic line_end();
        wait_drain();
        @(posedge Clk); #1;
        LineEnd = 1'b1;
        fm_line++;
        fm_col = 0;
        @(posedge Clk); #1;
        LineEnd = 1'b0;
    endtask

    task automatic run_lines(input int lines, input bit rand_gap, input bit chk_addr);
        for (int l = 0; l < lines; l++) begin
            for (int i = 0; i < fm_B; i++)
                fetch(rand_gap ? 4 + int'($urandom_range(0, 3)) : 4, chk_addr);
            line_end();
        end
    endtask

    task automatic host_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        @(posedge Clk); #1;
        HostReq = 1'b1; HostWe = we; HostAddr = a; HostWData = d;
        if (we) golden[a] = d;
        got = 1'b0;
        for (int w = 0; w < 30 && !got; w++) begin
            @(negedge Clk);
            if (HostAck) got = 1'b1;
        end
        check_eq("host_ack", 32'(got), 1);
        if (got && !we) check_eq("host_rdata", 32'(HostRData), 32'(golden[a]));
        @(posedge Clk); #1;
        HostReq = 1'b0;
        @(negedge Clk);
        check_eq("host_ack_once", 32'(HostAck), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_outs"}, 32'({HostAck, HostRData, RamAddr, RamWe, RamWData,
                                      VidData, VidValid, FetchOverrun}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        for (int i = 0; i < 8192; i++) begin
            ram[i]    = DW'($urandom);
            golden[i] = ram[i];
        end

        // Reset state
        #12;
        check_outputs_zero("reset");
        @(posedge Clk); #1 Reset = 1'b0;

        // Reset in the middle of a host write
        @(posedge Clk); #1;
        HostReq = 1'b1; HostWe = 1'b1; HostAddr = 13'h1234; HostWData = 8'hA5;
        for (int w = 0; w < 10 && RamWe !== 1'b1; w++) @(negedge Clk);
        check_eq("reset_setup_we", 32'(RamWe), 1);
        #2 Reset = 1'b1;
        #1;
        check_eq("reset_we_drop", 32'(RamWe), 0);
        check_outputs_zero("reset_mid");
        HostReq = 1'b0; HostWe = 1'b0;
        @(posedge Clk); #1 Reset = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge Clk);
            if (HostAck) acks++;
        end
        check_eq("reset_no_ack", 32'(acks), 0);
        check_eq("reset_no_write", 32'(ram[13'h1234]), 32'(golden[13'h1234]));

        // Graphics fetch walk, two lines at 0x0400
        min_lat = 3; max_lat = 3;
        frame_start(1'b1, 3'b110, 13'h0400);
        run_lines(2, 1'b0, 1'b1);

        // Alpha repeat, 13 lines at 0
        frame_start(1'b0, 3'b000, 13'h0000);
        run_lines(13, 1'b0, 1'b1);

        // Address wrap
        frame_start(1'b1, 3'b111, 13'h1FF0);
        run_lines(2, 1'b0, 1'b1);
        check_eq("no_overrun_directed", 32'(FetchOverrun), 0);

        // Interleave a host write and read-back with a steady fetch cadence
        min_lat = 3; max_lat = 5;
        frame_start(1'b0, 3'b000, 13'h0100);
        fork
            for (int i = 0; i < 32; i++) fetch(4, 1'b0);
            begin
                repeat (3) @(posedge Clk);
                host_op(1'b1, 13'h1000, 8'h5A);
                host_op(1'b0, 13'h1000, 8'h00);
            end
        join
        line_end();

        // Randomized frames with concurrent host traffic
        for (int f = 0; f < 4; f++) begin
            frame_start(1'($urandom), 3'($urandom), AW'($urandom_range(0, 13'h07FF)));
            fork
                run_lines(int'($urandom_range(1, 4)), 1'b1, 1'b0);
                for (int h = 0; h < 8; h++) begin
                    repeat ($urandom_range(0, 6)) @(posedge Clk);
                    host_op(1'($urandom), AW'(13'h1000 | ($urandom & 32'h0FFF)), DW'($urandom));
                end
            join
        end
        check_eq("no_overrun_random", 32'(FetchOverrun), 0);

        // Collision: fetch during HOST, second fetch during HCAP is lost
        wait_drain();
        repeat (3) @(posedge Clk);
        frame_start(1'b1, 3'b110, 13'h0800);
        min_lat = 5; max_lat = 5;
        begin
            fetch_t t;
            @(posedge Clk); #1;
            HostReq = 1'b1; HostWe = 1'b0; HostAddr = 13'h1ABC;
            @(posedge Clk); #1;
            FetchReq = 1'b1;
            t.addr = exp_addr();
            t.cyc  = cyc;
            vq.push_back(t);
            fm_col++;
            @(posedge Clk); #1;
            @(posedge Clk); #1;
            FetchReq = 1'b0;
            @(negedge Clk);
            check_eq("coll_host_ack", 32'(HostAck), 1);
            check_eq("coll_host_rdata", 32'(HostRData), 32'(golden[13'h1ABC]));
            @(posedge Clk); #1;
            HostReq = 1'b0;
        end
        wait_drain();
        check_eq("overrun_set", 32'(FetchOverrun), 1);
        min_lat = 3; max_lat = 3;
        fetch(4, 1'b1);
        repeat (10) @(posedge Clk);
        wait_drain();
        check_eq("overrun_sticky", 32'(FetchOverrun), 1);

        // Only Reset clears the overrun flag
        @(posedge Clk); #1 Reset = 1'b1;
        #2;
        check_outputs_zero("reset_end");
        @(posedge Clk); #1 Reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
